// File: rtl/hazard_controller_pkg.sv
// Shared pipeline encodings for the RV32I hazard controller: result selects,
// forward selects and the hazard FSM state type.
package pipeline_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } hz_state_t;

    // Loads and stores both occupy the data memory in the M stage.
    function automatic logic is_mem_access(input logic [1:0] result_src, input logic mem_write);
        return (result_src == RES_MEM) || mem_write;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side view of the hazard controller: register tags and controls in,
// forward selects, stall/flush strobes and status out.
interface hazard_controller_if #(
    parameter int A_WIDTH   = 5,
    parameter int CNT_WIDTH = 32
);
    logic [A_WIDTH-1:0]   Rs1D, Rs2D;
    logic [A_WIDTH-1:0]   Rs1E, Rs2E, RdE;
    logic [1:0]           ResultSrcE;
    logic                 PCSrcE;
    logic [A_WIDTH-1:0]   RdM;
    logic                 RegWriteM;
    logic [1:0]           ResultSrcM;
    logic                 MemWriteM;
    logic                 mem_ready;
    logic [A_WIDTH-1:0]   RdW;
    logic                 RegWriteW;

    logic [1:0]           ForwardAE, ForwardBE;
    logic                 StallF, StallD, StallE, StallM;
    logic                 FlushD, FlushE, FlushW;
    logic                 mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, ResultSrcM, MemWriteM, mem_ready, RdW, RegWriteW,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, ResultSrcM, MemWriteM, mem_ready, RdW, RegWriteW,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, mem_timeout, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_controller_forward_unit.sv
// One execute-stage operand forward select; the M stage holds the younger
// result, so it wins over W.
module forward_unit
    import pipeline_pkg::*;
#(
    parameter int A_WIDTH = 5
) (
    input  logic [A_WIDTH-1:0] i_rs,
    input  logic [A_WIDTH-1:0] i_rd_m,
    input  logic               i_reg_write_m,
    input  logic [A_WIDTH-1:0] i_rd_w,
    input  logic               i_reg_write_w,
    output logic [1:0]         o_forward
);

    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs);
    assign w_hit_w = i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs);

    always_comb begin
        o_forward = FWD_RF;
        if (w_hit_m) begin
            o_forward = FWD_M;
        end else if (w_hit_w) begin
            o_forward = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use
// stalls, branch flushes and a watchdog-guarded freeze for slow data memory.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int A_WIDTH   = 5,
    parameter int CNT_WIDTH = 32,
    parameter int MAX_WAIT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_controller_if.slave hz
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    hz_state_t            r_state;
    hz_state_t            w_next_state;
    logic                 r_flush_pending;
    logic                 w_next_flush_pending;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic [WAIT_W-1:0]    w_next_wait_cnt;
    logic                 r_mem_timeout;
    logic                 w_next_mem_timeout;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_flush_count;

    logic [1:0]           w_fwd_a;
    logic [1:0]           w_fwd_b;
    logic                 w_mem_m;
    logic                 w_load_use;
    logic                 w_branch;
    logic                 w_freeze;
    logic                 w_lu_stall;
    logic                 w_branch_flush;
    logic                 w_stall_f;

    forward_unit #(.A_WIDTH(A_WIDTH)) u_fwd_a (
        .i_rs          (hz.Rs1E),
        .i_rd_m        (hz.RdM),
        .i_reg_write_m (hz.RegWriteM),
        .i_rd_w        (hz.RdW),
        .i_reg_write_w (hz.RegWriteW),
        .o_forward     (w_fwd_a)
    );

    forward_unit #(.A_WIDTH(A_WIDTH)) u_fwd_b (
        .i_rs          (hz.Rs2E),
        .i_rd_m        (hz.RdM),
        .i_reg_write_m (hz.RegWriteM),
        .i_rd_w        (hz.RdW),
        .i_reg_write_w (hz.RegWriteW),
        .o_forward     (w_fwd_b)
    );

    assign w_mem_m    = is_mem_access(hz.ResultSrcM, hz.MemWriteM);
    assign w_load_use = (hz.ResultSrcE == RES_MEM) && (hz.RdE != '0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    // A branch resolved during a freeze is replayed on the first free cycle.
    assign w_branch   = hz.PCSrcE || r_flush_pending;

    always_comb begin
        w_next_state         = r_state;
        w_next_flush_pending = r_flush_pending;
        w_next_wait_cnt      = r_wait_cnt;
        w_next_mem_timeout   = r_mem_timeout;
        w_freeze             = 1'b0;
        w_lu_stall           = 1'b0;
        w_branch_flush       = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_m && !hz.mem_ready) begin
                    w_freeze             = 1'b1;
                    w_next_state         = MEM_WAIT;
                    w_next_wait_cnt      = WAIT_W'(1);
                    w_next_flush_pending = w_branch;
                end else if (w_branch) begin
                    w_branch_flush       = 1'b1;
                    w_next_flush_pending = 1'b0;
                end else if (w_load_use) begin
                    w_lu_stall           = 1'b1;
                end
            end
            MEM_WAIT: begin
                w_freeze             = 1'b1;
                w_next_flush_pending = r_flush_pending || hz.PCSrcE;
                if (hz.mem_ready) begin
                    w_next_state = RUN;
                end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    w_next_state       = ERROR;
                    w_next_mem_timeout = 1'b1;
                end else begin
                    w_next_wait_cnt = r_wait_cnt + WAIT_W'(1);
                end
            end
            ERROR: begin
                w_freeze           = 1'b1;
                w_next_mem_timeout = 1'b1;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    assign w_stall_f = w_freeze || w_lu_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= RUN;
            r_flush_pending <= 1'b0;
            r_wait_cnt      <= '0;
            r_mem_timeout   <= 1'b0;
            r_stall_cycles  <= '0;
            r_flush_count   <= '0;
        end else begin
            r_state         <= w_next_state;
            r_flush_pending <= w_next_flush_pending;
            r_wait_cnt      <= w_next_wait_cnt;
            r_mem_timeout   <= w_next_mem_timeout;
            if (w_stall_f && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
            if (w_branch_flush && (r_flush_count != {CNT_WIDTH{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_WIDTH'(1);
            end
        end
    end

    // Strobes are held quiet for as long as reset is asserted.
    assign hz.ForwardAE    = rst_n ? w_fwd_a : FWD_RF;
    assign hz.ForwardBE    = rst_n ? w_fwd_b : FWD_RF;
    assign hz.StallF       = rst_n && w_stall_f;
    assign hz.StallD       = rst_n && w_stall_f;
    assign hz.StallE       = rst_n && w_freeze;
    assign hz.StallM       = rst_n && w_freeze;
    assign hz.FlushD       = rst_n && w_branch_flush;
    assign hz.FlushE       = rst_n && (w_branch_flush || w_lu_stall);
    assign hz.FlushW       = rst_n && w_freeze;
    assign hz.mem_timeout  = r_mem_timeout;
    assign hz.stall_cycles = r_stall_cycles;
    assign hz.flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Randomised self-checking bench for hazard_controller against a behavioural
// model of the pipeline hazard rules, plus directed literal checks.
module tb_hazard_controller;

    localparam int AW   = 5;
    localparam int CW   = 32;
    localparam int MAXW = 4;

    typedef struct {
        logic          rst;
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0]    resE, resM;
        logic          pc, rwm, mwm, rdy, rww;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checkCount = 0;
    int   passCount  = 0;

    hazard_controller_if #(.A_WIDTH(AW), .CNT_WIDTH(CW)) hif ();

    hazard_controller #(.A_WIDTH(AW), .CNT_WIDTH(CW), .MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s.rst = 1'b1;
        s.rs1d = '0; s.rs2d = '0; s.rs1e = '0; s.rs2e = '0;
        s.rde = '0;  s.rdm = '0;  s.rdw = '0;
        s.resE = 2'b00; s.resM = 2'b00;
        s.pc = 1'b0; s.rwm = 1'b0; s.mwm = 1'b0; s.rdy = 1'b1; s.rww = 1'b0;
        return s;
    endfunction

    task automatic driveNow(input stim_t s);
        rst_n          = s.rst;
        hif.Rs1D       = s.rs1d;
        hif.Rs2D       = s.rs2d;
        hif.Rs1E       = s.rs1e;
        hif.Rs2E       = s.rs2e;
        hif.RdE        = s.rde;
        hif.ResultSrcE = s.resE;
        hif.PCSrcE     = s.pc;
        hif.RdM        = s.rdm;
        hif.RegWriteM  = s.rwm;
        hif.ResultSrcM = s.resM;
        hif.MemWriteM  = s.mwm;
        hif.mem_ready  = s.rdy;
        hif.RdW        = s.rdw;
        hif.RegWriteW  = s.rww;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        driveNow(s);
    endtask

    task automatic sampleMid();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model: an outstanding memory access either drains, or dies
    // after MAXW further unready cycles; branches seen while frozen are deferred.
    logic        mBusy = 1'b0, mDead = 1'b0, mDefer = 1'b0;
    int          mAge = 0;
    logic [31:0] mStall = '0, mFlush = '0;
    logic        nBusy = 1'b0, nDead = 1'b0, nDefer = 1'b0;
    int          nAge = 0;
    logic [31:0] nStall = '0, nFlush = '0;

    logic [1:0]  eFwdA, eFwdB;
    logic        eSF, eSD, eSE, eSM, eFD, eFE, eFW;
    logic        memAccess, branchNow, loadUse;

    function automatic logic [1:0] modelForward(input logic [AW-1:0] rs);
        if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == rs) return 2'd2;
        if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == rs) return 2'd1;
        return 2'd0;
    endfunction

    always @(negedge clk) begin
        {eFwdA, eFwdB} = '0;
        {eSF, eSD, eSE, eSM, eFD, eFE, eFW} = '0;
        nBusy = mBusy; nDead = mDead; nDefer = mDefer; nAge = mAge;
        nStall = mStall; nFlush = mFlush;
        if (!rst_n) begin
            nBusy = 1'b0; nDead = 1'b0; nDefer = 1'b0; nAge = 0;
            nStall = '0; nFlush = '0;
        end else begin
            eFwdA     = modelForward(hif.Rs1E);
            eFwdB     = modelForward(hif.Rs2E);
            memAccess = (hif.ResultSrcM == 2'b01) || hif.MemWriteM;
            branchNow = hif.PCSrcE || mDefer;
            loadUse   = (hif.ResultSrcE == 2'b01) && (hif.RdE != 0) &&
                        (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
            if (mDead || mBusy || (memAccess && !hif.mem_ready)) begin
                {eSF, eSD, eSE, eSM, eFW} = 5'b11111;
                if (mDead) begin
                    nDead = 1'b1;
                end else if (mBusy) begin
                    nDefer = mDefer || hif.PCSrcE;
                    if (hif.mem_ready) nBusy = 1'b0;
                    else if (mAge == MAXW) nDead = 1'b1;
                    else nAge = mAge + 1;
                end else begin
                    nBusy = 1'b1; nAge = 1; nDefer = branchNow;
                end
            end else if (branchNow) begin
                eFD = 1'b1; eFE = 1'b1; nDefer = 1'b0;
                if (mFlush != 32'hFFFF_FFFF) nFlush = mFlush + 1;
            end else if (loadUse) begin
                eSF = 1'b1; eSD = 1'b1; eFE = 1'b1;
            end
            if (eSF && mStall != 32'hFFFF_FFFF) nStall = mStall + 1;
        end
        checkOutput("ForwardAE", 32'(hif.ForwardAE), 32'(eFwdA));
        checkOutput("ForwardBE", 32'(hif.ForwardBE), 32'(eFwdB));
        checkOutput("StallF", 32'(hif.StallF), 32'(eSF));
        checkOutput("StallD", 32'(hif.StallD), 32'(eSD));
        checkOutput("StallE", 32'(hif.StallE), 32'(eSE));
        checkOutput("StallM", 32'(hif.StallM), 32'(eSM));
        checkOutput("FlushD", 32'(hif.FlushD), 32'(eFD));
        checkOutput("FlushE", 32'(hif.FlushE), 32'(eFE));
        checkOutput("FlushW", 32'(hif.FlushW), 32'(eFW));
        checkOutput("mem_timeout", 32'(hif.mem_timeout), 32'(mDead));
        checkOutput("stall_cycles", hif.stall_cycles, mStall);
        checkOutput("flush_count", hif.flush_count, mFlush);
    end

    always @(posedge clk) begin
        mBusy = nBusy; mDead = nDead; mDefer = nDefer; mAge = nAge;
        mStall = nStall; mFlush = nFlush;
    end

    initial begin
        stim_t s;
        s = idleStim();
        s.rst = 1'b0; s.rdm = 5; s.rwm = 1'b1; s.rs1e = 5;
        s.pc = 1'b1; s.resM = 2'b01; s.rdy = 1'b0;
        driveNow(s);
        applyStimulus(s);
        sampleMid();
        checkOutput("lit_rst_fwdA", 32'(hif.ForwardAE), 32'd0);
        checkOutput("lit_rst_stallF", 32'(hif.StallF), 32'd0);
        checkOutput("lit_rst_flushD", 32'(hif.FlushD), 32'd0);
        checkOutput("lit_rst_stall_cycles", hif.stall_cycles, 32'd0);
        checkOutput("lit_rst_flush_count", hif.flush_count, 32'd0);
        checkOutput("lit_rst_timeout", 32'(hif.mem_timeout), 32'd0);

        s = idleStim();
        s.rdm = 5; s.rwm = 1'b1; s.rdw = 5; s.rww = 1'b1; s.rs1e = 5;
        applyStimulus(s); sampleMid();
        checkOutput("lit_fwdA_M", 32'(hif.ForwardAE), 32'd2);
        s.rdm = 0;
        applyStimulus(s); sampleMid();
        checkOutput("lit_fwdA_W", 32'(hif.ForwardAE), 32'd1);
        s.rs2e = 0; s.rdw = 0;
        applyStimulus(s); sampleMid();
        checkOutput("lit_fwdB_RF", 32'(hif.ForwardBE), 32'd0);

        s = idleStim();
        s.resE = 2'b01; s.rde = 7; s.rs2d = 7;
        applyStimulus(s); sampleMid();
        checkOutput("lit_lu_stallF", 32'(hif.StallF), 32'd1);
        checkOutput("lit_lu_flushE", 32'(hif.FlushE), 32'd1);
        applyStimulus(idleStim()); sampleMid();
        checkOutput("lit_lu_release", 32'(hif.StallF), 32'd0);
        checkOutput("lit_lu_stall_cycles", hif.stall_cycles, 32'd1);

        s.pc = 1'b1;
        applyStimulus(s); sampleMid();
        checkOutput("lit_br_flushD", 32'(hif.FlushD), 32'd1);
        checkOutput("lit_br_stallF", 32'(hif.StallF), 32'd0);
        applyStimulus(idleStim()); sampleMid();
        checkOutput("lit_br_flush_count", hif.flush_count, 32'd1);

        s = idleStim();
        s.resM = 2'b01; s.rdy = 1'b0;
        applyStimulus(s); sampleMid();
        checkOutput("lit_mw_stallM", 32'(hif.StallM), 32'd1);
        checkOutput("lit_mw_flushW", 32'(hif.FlushW), 32'd1);
        s.pc = 1'b1;
        applyStimulus(s); sampleMid();
        checkOutput("lit_mw_noflushD", 32'(hif.FlushD), 32'd0);
        s.pc = 1'b0;
        applyStimulus(s);
        s.rdy = 1'b1;
        applyStimulus(s); sampleMid();
        checkOutput("lit_mw_last_freeze", 32'(hif.StallF), 32'd1);
        applyStimulus(idleStim()); sampleMid();
        checkOutput("lit_mw_deferred_flushD", 32'(hif.FlushD), 32'd1);
        checkOutput("lit_mw_stall_cycles", hif.stall_cycles, 32'd5);
        applyStimulus(idleStim()); sampleMid();
        checkOutput("lit_mw_flush_count", hif.flush_count, 32'd2);

        s = idleStim();
        s.resM = 2'b01; s.rdy = 1'b0;
        for (int i = 0; i < MAXW + 1; i++) applyStimulus(s);
        sampleMid();
        checkOutput("lit_to_not_yet", 32'(hif.mem_timeout), 32'd0);
        s.rdy = 1'b1;
        applyStimulus(s); sampleMid();
        checkOutput("lit_to_set", 32'(hif.mem_timeout), 32'd1);
        checkOutput("lit_to_frozen", 32'(hif.StallF), 32'd1);
        applyStimulus(idleStim()); applyStimulus(idleStim()); sampleMid();
        checkOutput("lit_to_held", 32'(hif.StallE), 32'd1);
        s = idleStim(); s.rst = 1'b0;
        applyStimulus(s); sampleMid();
        checkOutput("lit_to_rst_stallF", 32'(hif.StallF), 32'd0);
        checkOutput("lit_to_rst_flushW", 32'(hif.FlushW), 32'd0);
        applyStimulus(idleStim()); sampleMid();
        checkOutput("lit_to_cleared", 32'(hif.mem_timeout), 32'd0);
        checkOutput("lit_to_stall_cycles", hif.stall_cycles, 32'd0);

        s = idleStim();
        s.resM = 2'b01; s.rdy = 1'b0;
        applyStimulus(s);
        s.pc = 1'b1;
        applyStimulus(s);
        s.pc = 1'b0; s.rst = 1'b0;
        applyStimulus(s);
        applyStimulus(idleStim()); sampleMid();
        checkOutput("lit_rmw_noflushD", 32'(hif.FlushD), 32'd0);
        checkOutput("lit_rmw_flush_count", hif.flush_count, 32'd0);
        checkOutput("lit_rmw_stall_cycles", hif.stall_cycles, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            s.rst  = ($urandom_range(99) != 0);
            s.rs1d = AW'($urandom_range(7));
            s.rs2d = AW'($urandom_range(7));
            s.rs1e = AW'($urandom_range(7));
            s.rs2e = AW'($urandom_range(7));
            s.rde  = AW'($urandom_range(7));
            s.rdm  = AW'($urandom_range(7));
            s.rdw  = AW'($urandom_range(7));
            s.resE = 2'($urandom_range(3));
            s.resM = 2'($urandom_range(3));
            s.pc   = ($urandom_range(99) < 15);
            s.rwm  = 1'($urandom_range(1));
            s.rww  = 1'($urandom_range(1));
            s.mwm  = ($urandom_range(9) == 0);
            s.rdy  = ($urandom_range(99) < 70);
            applyStimulus(s);
        end
        applyStimulus(idleStim());
        sampleMid();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
